// File: rtl/uart_rx_fifo_if.sv
// Receive-side output bus: head-of-FIFO frame, status flags and the pop handshake.
interface uart_rx_fifo_if #(
  parameter int MAX_BITS   = 9,
  parameter int FIFO_DEPTH = 8
);
  logic [MAX_BITS-1:0]         dout;
  logic                        dout_parity_err;
  logic                        dout_frame_err;
  logic                        dout_break;
  logic                        dout_valid;
  logic                        dout_ready;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        overrun;

  modport master (
    output dout, dout_parity_err, dout_frame_err, dout_break,
    output dout_valid, fifo_count, overrun,
    input  dout_ready
  );

  modport slave (
    input  dout, dout_parity_err, dout_frame_err, dout_break,
    input  dout_valid, fifo_count, overrun,
    output dout_ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver: 2-of-3 majority sampling, false-start rejection,
// parity/framing/break status, first-word-fall-through output FIFO.
module uart_rx_fifo #(
  parameter int OVERSAMPLE = 16,
  parameter int MAX_BITS   = 9,
  parameter int FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           sample_tick,
  input  logic           rx,
  input  logic [3:0]     frame_length,
  input  logic           parity_en,
  input  logic           parity_type,
  input  logic           stop2,
  uart_rx_fifo_if.master out_if
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = MAX_BITS + 3;
  localparam logic [CW-1:0] CNT_S0   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] CNT_DEC  = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LEN_MAX  = 4'(MAX_BITS);
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK} state_t;

  logic [1:0]          rst_sync_q;
  logic                rst_n;
  logic                rx_meta_q, rx_s_q;
  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [3:0]          bit_q, bit_d;
  logic                stop_q, stop_d;
  logic                s0_q, s0_d, s1_q, s1_d;
  logic [MAX_BITS-1:0] data_q, data_d;
  logic                par_q, par_d;
  logic                ferr_q, ferr_d;
  logic [3:0]          len_q, len_d;
  logic                pen_q, pen_d, ptype_q, ptype_d, stop2_q, stop2_d;
  logic                vote, dec, wrap, last_stop;
  logic                push, ferr_now, perr, brk;
  logic [EW-1:0]       mem_q [FIFO_DEPTH];
  logic [EW-1:0]       head, entry;
  logic [PW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]         count_q, count_d;
  logic                ovr_q, ovr_d;
  logic                valid, pop, full, do_push;

  // Reset asserts asynchronously and releases on a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // Two-flop synchroniser for the asynchronous rx pad; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign vote      = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);
  assign dec       = sample_tick && (cnt_q == CNT_DEC);
  assign wrap      = sample_tick && (cnt_q == CNT_LAST);
  assign last_stop = !stop2_q || stop_q;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (sample_tick && !rx_s_q) state_d = S_START;
      S_START:  if (dec && vote) state_d = S_IDLE;
                else if (wrap) state_d = S_DATA;
      S_DATA:   if (wrap && (bit_q == len_q)) state_d = pen_q ? S_PARITY : S_STOP;
      S_PARITY: if (wrap) state_d = S_STOP;
      S_STOP:   if (dec && last_stop) state_d = brk ? S_BRK : S_IDLE;
      S_BRK:    if (sample_tick && rx_s_q) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: frame completion and its status flags.
  always_comb begin
    push     = (state_q == S_STOP) && dec && last_stop;
    ferr_now = ferr_q | ((state_q == S_STOP) && dec && !vote);
    perr     = pen_q & (^data_q ^ par_q ^ ptype_q);
    brk      = ferr_now && (data_q == '0) && !(pen_q && par_q);
    entry    = {brk, ferr_now, perr, data_q};
  end

  // Bit timing, sampling, shifting and per-frame config capture.
  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    data_d  = data_q;
    par_d   = par_q;
    ferr_d  = ferr_q;
    len_d   = len_q;
    pen_d   = pen_q;
    ptype_d = ptype_q;
    stop2_d = stop2_q;
    if (sample_tick) begin
      if (state_q == S_IDLE) begin
        if (!rx_s_q) begin
          cnt_d   = '0;
          bit_d   = '0;
          stop_d  = 1'b0;
          data_d  = '0;
          par_d   = 1'b0;
          ferr_d  = 1'b0;
          len_d   = (frame_length < 4'd5) ? 4'd5 :
                    (frame_length > LEN_MAX) ? LEN_MAX : frame_length;
          pen_d   = parity_en;
          ptype_d = parity_type;
          stop2_d = stop2;
        end
      end else if (state_q != S_BRK) begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        if (cnt_q == CNT_S0) s0_d = rx_s_q;
        if (cnt_q == CNT_S1) s1_d = rx_s_q;
        if (cnt_q == CNT_DEC) begin
          case (state_q)
            S_DATA: begin
              for (int i = 0; i < MAX_BITS; i++)
                if (bit_q == 4'(i)) data_d[i] = vote;
              bit_d = bit_q + 1'b1;
            end
            S_PARITY: par_d = vote;
            S_STOP: begin
              if (!vote) ferr_d = 1'b1;
              stop_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Receiver datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      data_q  <= '0;
      par_q   <= 1'b0;
      ferr_q  <= 1'b0;
      len_q   <= 4'd8;
      pen_q   <= 1'b0;
      ptype_q <= 1'b0;
      stop2_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      data_q  <= data_d;
      par_q   <= par_d;
      ferr_q  <= ferr_d;
      len_q   <= len_d;
      pen_q   <= pen_d;
      ptype_q <= ptype_d;
      stop2_q <= stop2_d;
    end
  end

  assign valid = (count_q != '0);
  assign full  = (count_q == CNT_FULL);
  assign pop   = valid & out_if.dout_ready;
  assign head  = mem_q[rd_q];

  // FIFO pointer/count update; a full FIFO still accepts a push paired with a pop.
  always_comb begin
    do_push = push && (!full || pop);
    ovr_d   = push && full && !pop;
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    count_d = count_q;
    if (do_push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !do_push) count_d = count_q - 1'b1;
  end

  // FIFO control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovr_q   <= ovr_d;
    end
  end

  // FIFO storage; contents are qualified by the count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= entry;
  end

  assign out_if.dout            = valid ? head[MAX_BITS-1:0] : '0;
  assign out_if.dout_parity_err = valid & head[MAX_BITS];
  assign out_if.dout_frame_err  = valid & head[MAX_BITS+1];
  assign out_if.dout_break      = valid & head[MAX_BITS+2];
  assign out_if.dout_valid      = valid;
  assign out_if.fifo_count      = count_q;
  assign out_if.overrun         = ovr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: table of single frames plus hand-written
// false-start, break, overrun and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int OS           = 16;
  localparam int CLK_PER_TICK = 2;
  localparam int BIT_CLKS     = OS * CLK_PER_TICK;
  localparam int NV           = 11;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sample_tick = 1'b0;
  logic       rx = 1'b1;
  logic [3:0] frame_length = 4'd8;
  logic       parity_en = 1'b0;
  logic       parity_type = 1'b0;
  logic       stop2 = 1'b0;
  int         checks = 0;
  int         failures = 0;
  int         ovr_pulses = 0;
  int         ovr0;

  uart_rx_fifo_if #(.MAX_BITS(9), .FIFO_DEPTH(8)) bus ();

  uart_rx_fifo #(.OVERSAMPLE(OS), .MAX_BITS(9), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .rx(rx),
    .frame_length(frame_length), .parity_en(parity_en),
    .parity_type(parity_type), .stop2(stop2), .out_if(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) sample_tick <= ~sample_tick;
  always @(negedge clk) if (bus.overrun) ovr_pulses++;

  typedef struct {
    logic [3:0] cfg_len;
    int         nbits;
    logic       pen, ptype, pbit, two, st1, st2;
    logic [8:0] data;
    logic [8:0] exp_dout;
    logic       exp_perr, exp_ferr, exp_brk;
  } vec_t;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(posedge clk);
  endtask

  task automatic send_frame(input logic [8:0] d, input int n, input logic pen,
                            input logic pb, input logic two, input logic s1, input logic s2);
    send_bit(1'b0);
    for (int i = 0; i < n; i++) send_bit(d[i]);
    if (pen) send_bit(pb);
    send_bit(s1);
    if (two) send_bit(s2);
    send_bit(1'b1);
  endtask

  task automatic pop_one();
    @(negedge clk);
    bus.dout_ready = 1'b1;
    @(negedge clk);
    bus.dout_ready = 1'b0;
  endtask

  task automatic set_cfg(input logic [3:0] len, input logic pen, input logic pt, input logic s2);
    frame_length = len;
    parity_en    = pen;
    parity_type  = pt;
    stop2        = s2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dout"},  bus.dout, 0);
    chk({tag, "_valid"}, bus.dout_valid, 0);
    chk({tag, "_count"}, bus.fifo_count, 0);
    chk({tag, "_flags"}, {bus.dout_parity_err, bus.dout_frame_err, bus.dout_break}, 0);
    chk({tag, "_ovr"},   bus.overrun, 0);
  endtask

  initial begin
    //          len    n  pen pt pb two st1 st2 data     exp      pe fe bk
    vecs[0]  = '{4'd8,  8, 0, 0, 0, 0, 1, 1, 9'h0A5, 9'h0A5, 0, 0, 0};
    vecs[1]  = '{4'd7,  7, 1, 0, 1, 0, 1, 1, 9'h035, 9'h035, 1, 0, 0};
    vecs[2]  = '{4'd7,  7, 1, 0, 0, 0, 1, 1, 9'h035, 9'h035, 0, 0, 0};
    vecs[3]  = '{4'd9,  9, 1, 1, 0, 1, 1, 0, 9'h1FF, 9'h1FF, 0, 1, 0};
    vecs[4]  = '{4'd5,  5, 0, 0, 0, 0, 1, 1, 9'h015, 9'h015, 0, 0, 0};
    vecs[5]  = '{4'd3,  5, 0, 0, 0, 0, 1, 1, 9'h00B, 9'h00B, 0, 0, 0};
    vecs[6]  = '{4'd15, 9, 0, 0, 0, 0, 1, 1, 9'h155, 9'h155, 0, 0, 0};
    vecs[7]  = '{4'd8,  8, 1, 1, 1, 0, 1, 1, 9'h000, 9'h000, 0, 0, 0};
    vecs[8]  = '{4'd8,  8, 0, 0, 0, 0, 0, 1, 9'h080, 9'h080, 0, 1, 0};
    vecs[9]  = '{4'd8,  8, 1, 0, 0, 0, 0, 1, 9'h000, 9'h000, 0, 1, 1};
    vecs[10] = '{4'd8,  8, 1, 0, 1, 0, 0, 1, 9'h000, 9'h000, 1, 1, 0};

    bus.dout_ready = 1'b0;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;
    repeat (4) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      set_cfg(vecs[i].cfg_len, vecs[i].pen, vecs[i].ptype, vecs[i].two);
      send_frame(vecs[i].data, vecs[i].nbits, vecs[i].pen, vecs[i].pbit,
                 vecs[i].two, vecs[i].st1, vecs[i].st2);
      @(negedge clk);
      chk($sformatf("v%0d_count", i), bus.fifo_count, 1);
      chk($sformatf("v%0d_valid", i), bus.dout_valid, 1);
      chk($sformatf("v%0d_dout", i), bus.dout, vecs[i].exp_dout);
      chk($sformatf("v%0d_perr", i), bus.dout_parity_err, vecs[i].exp_perr);
      chk($sformatf("v%0d_ferr", i), bus.dout_frame_err, vecs[i].exp_ferr);
      chk($sformatf("v%0d_brk", i), bus.dout_break, vecs[i].exp_brk);
      pop_one();
      chk($sformatf("v%0d_empty", i), bus.dout_valid, 0);
    end

    // False start: a 5-tick low glitch is rejected, then a clean frame.
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (5 * CLK_PER_TICK) @(posedge clk);
    rx = 1'b1;
    repeat (3 * BIT_CLKS) @(posedge clk);
    @(negedge clk);
    chk("fstart_count", bus.fifo_count, 0);
    send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("fstart_next_count", bus.fifo_count, 1);
    chk("fstart_next_dout", bus.dout, 9'h03C);
    pop_one();

    // Break: line held low for 20 bit times gives exactly one entry.
    rx = 1'b0;
    repeat (20 * BIT_CLKS) @(posedge clk);
    @(negedge clk);
    chk("brk_count", bus.fifo_count, 1);
    chk("brk_dout", bus.dout, 0);
    chk("brk_ferr", bus.dout_frame_err, 1);
    chk("brk_flag", bus.dout_break, 1);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(posedge clk);
    @(negedge clk);
    chk("brk_after_count", bus.fifo_count, 1);
    pop_one();
    send_frame(9'h055, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("brk_next_dout", bus.dout, 9'h055);
    chk("brk_next_brk", bus.dout_break, 0);
    pop_one();

    // Overrun: nine frames into an eight-entry FIFO, then drain in order.
    ovr0 = ovr_pulses;
    for (int k = 1; k <= 9; k++)
      send_frame(9'(k), 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("ovr_count", bus.fifo_count, 8);
    chk("ovr_pulses", ovr_pulses - ovr0, 1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("drain%0d", k), bus.dout, 9'(k));
      pop_one();
    end
    chk("drain_empty", bus.fifo_count, 0);

    // 9-bit odd parity, two stops with a bad 2nd stop, then reset mid-frame.
    set_cfg(4'd9, 1'b1, 1'b1, 1'b1);
    send_frame(9'h1FF, 9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("r_ferr_dout", bus.dout, 9'h1FF);
    chk("r_ferr_flag", bus.dout_frame_err, 1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx = 1'b1;
    repeat (BIT_CLKS / 2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (3 * BIT_CLKS) @(posedge clk);
    @(negedge clk);
    chk("midrst_after_count", bus.fifo_count, 0);
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("midrst_next_dout", bus.dout, 9'h0A5);
    chk("midrst_next_count", bus.fifo_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
